sv_ec_arbiter: RTL and testbench

//  Shares one signature/verification core among NUM_REQ requesters.
//  - Picks one pending requester by round-robin and forwards its program start address.
//  - Issues the single-cycle start strobe and tracks the core's ready signal through one job.
//  - Returns a done pulse, or an error pulse on watchdog timeout, to the granted requester.
//  - Sits between the protocol-level masters and the core's v_i/start_addr_i/ready pins.

---
 rtl/sv_ec_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sv_ec_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sv_ec_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sv_ec_arbiter
//  Purpose  : Round-robin arbiter sharing one signature/verification core
//             among NUM_REQ requesters. Forwards the granted requester's
//             program start address, issues a single-cycle start strobe,
//             tracks the core's ready level through one job and returns a
//             done pulse (or an err pulse on watchdog timeout) to the
//             granted requester.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1               rising-edge clock
//    areset       in   1               asynchronous reset, active-high
//    req_i        in   NUM_REQ         request level per requester
//    addr_i       in   NUM_REQ*ADDR_W  start address, slice k = requester k
//    gnt_o        out  NUM_REQ         one-hot grant, high for the whole job
//    done_o       out  NUM_REQ         1-cycle completion pulse
//    err_o        out  NUM_REQ         1-cycle timeout pulse
//    core_v_o     out  1               1-cycle start strobe to core
//    core_addr_o  out  ADDR_W          latched start address
//    core_ready_i in   1               core idle/ready level
//    busy_o       out  1               high whenever a job is in progress
// ============================================================================
module sv_ec_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 65535,
  parameter int TO_W    = 16
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic                      core_v_o,
  output logic [ADDR_W-1:0]         core_addr_o,
  input  logic                      core_ready_i,
  output logic                      busy_o
);

  localparam int              IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]  c_NREQ    = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] c_LAST   = IDX_W'(NUM_REQ-1);
  localparam logic [TO_W-1:0] c_TIMEOUT = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RELEASE   = 3'd4
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_idx;
  logic [TO_W-1:0]     r_wdog;
  logic                r_ready;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  r_err;
  logic                r_core_v;
  logic [ADDR_W-1:0]   r_core_addr;
  logic                r_busy;

  logic                w_found;
  logic [IDX_W-1:0]    w_sel;
  logic [IDX_W:0]      w_cand;
  logic [NUM_REQ-1:0]  w_sel_oh;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [TO_W-1:0]     w_wdog_nxt;

  // Round-robin pick: scan from the pointer upward, wrapping modulo NUM_REQ.
  // The wrap is done by subtraction so non-power-of-two NUM_REQ works.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= c_NREQ) begin
        w_cand = w_cand - c_NREQ;
      end
      if (!w_found && req_i[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_sel_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel;
  assign w_sel_addr = addr_i[w_sel*ADDR_W +: ADDR_W];
  assign w_wdog_nxt = r_wdog + 1'b1;

  // Job tracking looks at a registered copy of core_ready_i, so the done
  // pulse lands two cycles after ready rises. The IDLE launch check uses the
  // live pin so a blocked request is granted on the cycle after ready returns.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_wdog      <= '0;
      r_ready     <= 1'b0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_core_v    <= 1'b0;
      r_core_addr <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_ready <= core_ready_i;
      case (r_state)
        S_IDLE: begin
          if (w_found && core_ready_i) begin
            r_idx       <= w_sel;
            r_core_addr <= w_sel_addr;
            r_gnt       <= w_sel_oh;
            r_core_v    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          r_core_v <= 1'b0;
          r_wdog   <= '0;
          r_state  <= S_WAIT_BUSY;
        end

        S_WAIT_BUSY, S_WAIT_DONE: begin
          r_wdog <= w_wdog_nxt;
          // Completion is checked before the watchdog so a ready that
          // returns on the timeout cycle still reports done.
          if (r_state == S_WAIT_DONE && r_ready) begin
            r_done  <= r_gnt;
            r_state <= S_RELEASE;
          end else if (w_wdog_nxt == c_TIMEOUT) begin
            r_err   <= r_gnt;
            r_state <= S_RELEASE;
          end else if (r_state == S_WAIT_BUSY && !r_ready) begin
            r_state <= S_WAIT_DONE;
          end
        end

        S_RELEASE: begin
          r_done  <= '0;
          r_err   <= '0;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_ptr   <= (r_idx == c_LAST) ? '0 : r_idx + 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign core_v_o    = r_core_v;
  assign core_addr_o = r_core_addr;
  assign busy_o      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sv_ec_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sv_ec_arbiter
//  Purpose  : Directed self-checking bench for sv_ec_arbiter (4 requesters,
//             8-bit addresses, TIMEOUT=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sv_ec_arbiter;

  logic        clk;
  logic        areset;
  logic [3:0]  req;
  logic [31:0] addr;
  logic [3:0]  gnt_o;
  logic [3:0]  done_o;
  logic [3:0]  err_o;
  logic        core_v_o;
  logic [7:0]  core_addr_o;
  logic        ready;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;
  int cnt_v = 0;
  int cnt_done = 0;
  int cnt_err = 0;
  int bad_gnt = 0;
  int v0, d0, e0;

  logic [3:0] fair_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0] fair_addr[5] = '{8'h11, 8'h22, 8'h3C, 8'h44, 8'h11};

  sv_ec_arbiter #(
    .NUM_REQ(4), .ADDR_W(8), .TIMEOUT(16), .TO_W(16)
  ) u_dut (
    .clk         (clk),
    .areset      (areset),
    .req_i       (req),
    .addr_i      (addr),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .core_v_o    (core_v_o),
    .core_addr_o (core_addr_o),
    .core_ready_i(ready),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and grant one-hot monitor.
  always @(negedge clk) begin
    if (core_v_o) cnt_v++;
    if (|done_o) cnt_done++;
    if (|err_o) cnt_err++;
    if ($countones(gnt_o) > 1) bad_gnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_launch(input string tag, input logic [3:0] g, input logic [7:0] a);
    for (int i = 0; i < 20 && !core_v_o; i++) tick;
    chk({tag, "_v"}, core_v_o, 1);
    chk({tag, "_gnt"}, gnt_o, g);
    chk({tag, "_addr"}, core_addr_o, a);
  endtask

  // Entered in the LAUNCH cycle; plays the core: accept, stay busy, finish.
  task automatic finish_job(input string tag, input logic [3:0] g, input int nbusy);
    tick;
    ready = 1'b0;
    repeat (nbusy) tick;
    ready = 1'b1;
    for (int i = 0; i < 40 && !(|done_o) && !(|err_o); i++) tick;
    chk({tag, "_done"}, done_o, g);
    chk({tag, "_noerr"}, err_o, 0);
    tick;
    chk({tag, "_gntoff"}, gnt_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    req    = 4'b1111;
    ready  = 1'b1;
    addr   = {8'h44, 8'h3C, 8'h22, 8'h11};

    // Reset holds every output low despite pending requests.
    repeat (3) begin
      tick;
      chk("reset_outs", {gnt_o, done_o, err_o, core_v_o, busy_o, core_addr_o}, 0);
    end
    areset = 1'b0;

    // Fairness with all requests held, pointer starting at 0.
    v0 = cnt_v;
    for (int j = 0; j < 5; j++) begin
      wait_launch("fair", fair_gnt[j], fair_addr[j]);
      if (j == 4) req = 4'b0000;
      finish_job("fair", fair_gnt[j], 2);
    end
    chk("fair_vcount", cnt_v - v0, 5);

    // Ready low in IDLE blocks the grant.
    ready = 1'b0;
    req   = 4'b0001;
    repeat (3) begin
      tick;
      chk("blk_nogrant", gnt_o, 0);
    end
    ready = 1'b1;
    tick;
    chk("blk_gnt", gnt_o, 4'b0001);
    chk("blk_v", core_v_o, 1);
    req = 4'b0000;
    finish_job("blk", 4'b0001, 3);

    // Single job with exact latency; req dropped and addr changed after grant.
    v0 = cnt_v;
    d0 = cnt_done;
    req = 4'b0100;
    tick;
    chk("one_gnt", gnt_o, 4'b0100);
    chk("one_addr", core_addr_o, 8'h3C);
    chk("one_v", core_v_o, 1);
    chk("one_busy", busy_o, 1);
    tick;
    chk("one_v_off", core_v_o, 0);
    ready = 1'b0;
    req   = 4'b0000;
    addr[23:16] = 8'hFF;
    repeat (10) tick;
    ready = 1'b1;
    tick;
    chk("one_done_early", done_o, 0);
    tick;
    chk("one_done", done_o, 4'b0100);
    chk("one_gnt_rel", gnt_o, 4'b0100);
    chk("one_addr_hold", core_addr_o, 8'h3C);
    tick;
    chk("one_gnt_off", gnt_o, 0);
    chk("one_busy_off", busy_o, 0);
    chk("one_vcount", cnt_v - v0, 1);
    chk("one_dcount", cnt_done - d0, 1);
    addr[23:16] = 8'h3C;

    // Watchdog: core accepts but never returns ready.
    d0 = cnt_done;
    e0 = cnt_err;
    req = 4'b0001;
    tick;
    chk("to_v", core_v_o, 1);
    tick;
    ready = 1'b0;
    req   = 4'b0000;
    repeat (15) tick;
    chk("to_err_early", err_o, 0);
    tick;
    chk("to_err", err_o, 4'b0001);
    chk("to_nodone", done_o, 0);
    tick;
    chk("to_err_off", err_o, 0);
    chk("to_busy_off", busy_o, 0);
    chk("to_ecount", cnt_err - e0, 1);
    chk("to_dcount", cnt_done - d0, 0);
    ready = 1'b1;

    // Reset in WAIT_DONE abandons the job and clears the pointer.
    d0 = cnt_done;
    e0 = cnt_err;
    req = 4'b0010;
    tick;
    chk("mr_gnt", gnt_o, 4'b0010);
    tick;
    ready = 1'b0;
    req   = 4'b0000;
    repeat (4) tick;
    chk("mr_busy", busy_o, 1);
    #2 areset = 1'b1;
    #1;
    chk("mr_outs", {gnt_o, done_o, err_o, core_v_o, busy_o, core_addr_o}, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    ready  = 1'b1;
    req    = 4'b1111;
    tick;
    chk("mr_ptr0", gnt_o, 4'b0001);
    chk("mr_nopulse", (cnt_done - d0) + (cnt_err - e0), 0);
    req = 4'b0000;
    finish_job("mr_post", 4'b0001, 1);

    chk("gnt_onehot", bad_gnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
